// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the raster generator and its pixel source.
// The generator publishes the raster position; the source returns RGB some ticks later.
interface vga_timing_gen_if;
  logic [10:0] req_x;
  logic [9:0]  req_y;
  logic        req_valid;
  logic [7:0]  pixel_r;
  logic [7:0]  pixel_g;
  logic [7:0]  pixel_b;

  modport master (
    output req_x, req_y, req_valid,
    input  pixel_r, pixel_g, pixel_b
  );

  modport slave (
    input  req_x, req_y, req_valid,
    output pixel_r, pixel_g, pixel_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel-clock divider, H/V counters, sync decode,
// a delay chain matching the pixel-source latency and an aligned output register.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned PIPE_DLY = 0
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  vga_timing_gen_if.master        pix,
  output logic                    line_start,
  output logic                    frame_start,
  output logic                    VGA_CLK,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B
);

  localparam int unsigned H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS     = H_VIS + H_FP;
  localparam int unsigned H_SE     = H_SS + H_SYNC;
  localparam int unsigned V_SS     = V_VIS + V_FP;
  localparam int unsigned V_SE     = V_SS + V_SYNC;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } ctl_t;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             pix_ce;
  logic [10:0]      h_cnt;
  logic [9:0]       v_cnt;
  logic             h_last;
  logic             v_last;
  ctl_t             ctl_now;
  ctl_t             ctl_tail;

  // Pixel clock divider; VGA_CLK is registered from the next divider value so it
  // stays glitch-free and rises halfway through each pixel.
  assign pix_ce  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign div_nxt = pix_ce ? '0 : div_cnt + DIV_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      div_cnt <= '0;
      VGA_CLK <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      VGA_CLK <= (div_nxt >= DIV_W'(CLK_DIV / 2));
    end
  end

  assign h_last = (h_cnt == 11'(H_TOT - 1));
  assign v_last = (v_cnt == 10'(V_TOT - 1));

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  assign pix.req_x     = h_cnt;
  assign pix.req_y     = v_cnt;
  assign pix.req_valid = ctl_now.de;

  // Raw decode of the current position; polarity is applied only at the pins.
  assign ctl_now.de = (h_cnt < 11'(H_VIS)) && (v_cnt < 10'(V_VIS));
  assign ctl_now.hs = (h_cnt >= 11'(H_SS)) && (h_cnt < 11'(H_SE));
  assign ctl_now.vs = (v_cnt >= 10'(V_SS)) && (v_cnt < 10'(V_SE));

  // Delay the control decode by the pixel-source latency so it meets the returned data.
  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign ctl_tail = ctl_now;
    end else begin : g_dly
      ctl_t chain [PIPE_DLY];

      // NOTE: this array is reset on purpose; stale entries would leak onto the sync pins.
      always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
          for (int i = 0; i < int'(PIPE_DLY); i++) chain[i] <= '0;
        end else if (pix_ce) begin
          chain[0] <= ctl_now;
          for (int i = 1; i < int'(PIPE_DLY); i++) chain[i] <= chain[i-1];
        end
      end

      assign ctl_tail = chain[PIPE_DLY-1];
    end
  endgenerate

  // Output register: sync, blank and colour all switch on the same pixel tick.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= ~H_POL;
      VGA_VS      <= ~V_POL;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_ce) begin
      VGA_BLANK_N <= ctl_tail.de;
      VGA_HS      <= ctl_tail.hs ^ ~H_POL;
      VGA_VS      <= ctl_tail.vs ^ ~V_POL;
      VGA_R       <= ctl_tail.de ? pix.pixel_r : '0;
      VGA_G       <= ctl_tail.de ? pix.pixel_g : '0;
      VGA_B       <= ctl_tail.de ? pix.pixel_b : '0;
    end
  end

  // Wrap pulses land in the clock right after the wrapping tick, one clock wide.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && h_last;
      frame_start <= pix_ce && h_last && v_last;
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule
